// File: rtl/npc_mem_pkg.sv
// Shared encodings and lane helpers for the npc data-memory responder.
// memop follows RISC-V funct3 for loads/stores.
package npc_mem_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Unsigned variants only exist for loads.
    function automatic logic op_illegal(input logic [2:0] op, input logic wen);
        case (op)
            MOP_B, MOP_H, MOP_W: op_illegal = 1'b0;
            MOP_BU, MOP_HU:      op_illegal = wen;
            default:             op_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] addr);
        case (op)
            MOP_H, MOP_HU: misaligned = addr[0];
            MOP_W:         misaligned = |addr;
            default:       misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] op, input logic [1:0] addr);
        case (op)
            MOP_B, MOP_BU: lane_mask = 4'b0001 << addr;
            MOP_H, MOP_HU: lane_mask = addr[1] ? 4'b1100 : 4'b0011;
            MOP_W:         lane_mask = 4'b1111;
            default:       lane_mask = 4'b0000;
        endcase
    endfunction

    // Replicate right-aligned store data so every lane sees it; the mask picks one.
    function automatic logic [31:0] store_align(input logic [2:0] op, input logic [31:0] wdata);
        case (op)
            MOP_B:   store_align = {4{wdata[7:0]}};
            MOP_H:   store_align = {2{wdata[15:0]}};
            default: store_align = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] addr,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (addr)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = addr[1] ? word[31:16] : word[15:0];
        case (op)
            MOP_B:   load_extend = {{24{b[7]}}, b};
            MOP_BU:  load_extend = {24'h0, b};
            MOP_H:   load_extend = {{16{h[15]}}, h};
            MOP_HU:  load_extend = {16'h0, h};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/npc_dmem_array.sv
// Single-port word RAM: byte-enable synchronous write, combinational read.
// Contents are deliberately not reset.
module npc_dmem_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/npc_dmem_resp.sv
// Multi-cycle data-memory responder: accept one request, wait LAT cycles,
// perform the access, then hold the response until the CPU takes it.
module npc_dmem_resp
    import npc_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LAT         = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_wen,
    input  logic [2:0]  memop,
    input  logic [31:0] mem_addr,
    input  logic [31:0] memdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] mem_data,
    output logic        rsp_err
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam int          CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [2:0]         op_q, op_d;
    logic               wen_q, wen_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [31:0]        off;
    logic               in_range;
    logic               acc_err;
    logic               do_access;
    logic               arr_we;
    logic [31:0]        arr_rdata;

    // Range test is done on a 33-bit span so the upper bound cannot wrap.
    assign off       = addr_q - BASE_ADDR;
    assign in_range  = (addr_q >= BASE_ADDR) && ({1'b0, off} < SPAN);
    assign acc_err   = !in_range || op_illegal(op_q, wen_q) || misaligned(op_q, addr_q[1:0]);
    assign do_access = (state_q == BUSY) && (cnt_q == '0);
    assign arr_we    = do_access && wen_q && !acc_err;

    npc_dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk_i  (clk),
        .we_i   (arr_we),
        .be_i   (lane_mask(op_q, addr_q[1:0])),
        .addr_i (off[AW+1:2]),
        .wdata_i(store_align(op_q, wdata_q)),
        .rdata_o(arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            op_q    <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        op_d      = op_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = mem_addr;
                    op_d    = memop;
                    wen_d   = mem_wen;
                    wdata_d = memdata;
                    cnt_d   = CNT_W'(LAT - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    err_d   = acc_err;
                    rdata_d = (acc_err || wen_q) ? '0
                                                 : load_extend(op_q, addr_q[1:0], arr_rdata);
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_data = rdata_q;
    assign rsp_err  = err_q;

endmodule

// File: tb/tb_npc_dmem_resp.sv
// Bench for npc_dmem_resp: directed byte/half/word, error, backpressure and
// reset cases on a LAT=2 instance, plus a latency sweep on LAT=1 and LAT=5.
module tb_npc_dmem_resp;

    localparam int         LAT_MAIN = 2;
    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, mem_wen, rsp_ready;
    logic [2:0]  memop;
    logic [31:0] mem_addr, memdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] mem_data;

    logic        sv_req_valid, sv_rsp_ready;
    logic        l1_req_ready, l1_rsp_valid, l1_rsp_err;
    logic [31:0] l1_mem_data;
    logic        l5_req_ready, l5_rsp_valid, l5_rsp_err;
    logic [31:0] l5_mem_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];
    logic [31:0] model [8];

    npc_dmem_resp #(.LAT(LAT_MAIN)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .mem_wen(mem_wen), .memop(memop), .mem_addr(mem_addr), .memdata(memdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .mem_data(mem_data), .rsp_err(rsp_err)
    );

    npc_dmem_resp #(.LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(sv_req_valid), .req_ready(l1_req_ready),
        .mem_wen(mem_wen), .memop(memop), .mem_addr(mem_addr), .memdata(memdata),
        .rsp_valid(l1_rsp_valid), .rsp_ready(sv_rsp_ready), .mem_data(l1_mem_data),
        .rsp_err(l1_rsp_err)
    );

    npc_dmem_resp #(.LAT(5)) u_lat5 (
        .clk(clk), .rst(rst), .req_valid(sv_req_valid), .req_ready(l5_req_ready),
        .mem_wen(mem_wen), .memop(memop), .mem_addr(mem_addr), .memdata(memdata),
        .rsp_valid(l5_rsp_valid), .rsp_ready(sv_rsp_ready), .mem_data(l5_mem_data),
        .rsp_err(l5_rsp_err)
    );

    // Clock and global watchdog.
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference lane model, written independently of the design package.
    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] a,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (op)
            OP_B:    return {{24{b[7]}}, b};
            OP_BU:   return {24'h0, b};
            OP_H:    return {{16{h[15]}}, h};
            OP_HU:   return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] op, input logic [1:0] a,
                                                input logic [31:0] w, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (op)
            OP_B:    r[{a, 3'b000} +: 8] = d[7:0];
            OP_H:    r[{a[1], 4'b0000} +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    // Driver: wait for req_ready, present one request, push the expectation.
    task automatic send_req(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] exp_data,
                            input logic exp_err);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq("req_ready_idle", {31'h0, req_ready}, 32'h1);
        mem_wen   = wen;
        memop     = op;
        mem_addr  = addr;
        memdata   = data;
        req_valid = 1'b1;
        exp_q.push_back({exp_err, exp_data});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        mem_wen   = 1'($urandom);
        memop     = 3'($urandom);
        mem_addr  = $urandom;
        memdata   = $urandom;
    endtask

    // Collect one response, optionally holding rsp_ready low for `hold` cycles
    // while a competing request is presented.
    task automatic get_rsp(input int hold);
        int          cycles;
        logic [32:0] exp;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!rsp_valid && cycles < 60);
        check_eq("rsp_latency", cycles, LAT_MAIN);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
        check_eq("rsp_data", mem_data, exp[31:0]);
        check_eq("rsp_err", {31'h0, rsp_err}, {31'h0, exp[32]});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            mem_wen   = 1'b1;
            memop     = OP_W;
            mem_addr  = 32'h8000_0010;
            memdata   = 32'h0;
            @(posedge clk);
            #1;
            check_eq("bp_valid", {31'h0, rsp_valid}, 32'h1);
            check_eq("bp_data", mem_data, exp[31:0]);
            check_eq("bp_err", {31'h0, rsp_err}, {31'h0, exp[32]});
            check_eq("bp_req_ready", {31'h0, req_ready}, 32'h0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_eq("hs_valid_clr", {31'h0, rsp_valid}, 32'h0);
        check_eq("hs_data_clr", mem_data, 32'h0);
        check_eq("hs_err_clr", {31'h0, rsp_err}, 32'h0);
    endtask

    task automatic do_op(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_data,
                         input logic exp_err);
        send_req(wen, op, addr, data, exp_data, exp_err);
        get_rsp(0);
    endtask

    initial begin
        int l1_at, l5_at;
        rst = 1'b1; req_valid = 1'b0; mem_wen = 1'b0; memop = OP_W;
        mem_addr = 32'h0; memdata = 32'h0; rsp_ready = 1'b0;
        sv_req_valid = 1'b0; sv_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_req_ready", {31'h0, req_ready}, 32'h1);
        check_eq("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_eq("reset_mem_data", mem_data, 32'h0);
        check_eq("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Word store/load and lane behaviour
        do_op(1'b1, OP_W, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        do_op(1'b0, OP_W, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        do_op(1'b1, OP_B, 32'h8000_0013, 32'h1234_567F, 32'h0, 1'b0);
        do_op(1'b0, OP_B,  32'h8000_0013, 32'h0, 32'h0000_007F, 1'b0);
        do_op(1'b0, OP_B,  32'h8000_0012, 32'h0, 32'hFFFF_FFAD, 1'b0);
        do_op(1'b0, OP_BU, 32'h8000_0012, 32'h0, 32'h0000_00AD, 1'b0);
        do_op(1'b0, OP_H,  32'h8000_0012, 32'h0, 32'h0000_7FAD, 1'b0);
        do_op(1'b0, OP_HU, 32'h8000_0012, 32'h0, 32'h0000_7FAD, 1'b0);
        do_op(1'b0, OP_H,  32'h8000_0010, 32'h0, 32'hFFFF_BEEF, 1'b0);
        do_op(1'b0, OP_HU, 32'h8000_0010, 32'h0, 32'h0000_BEEF, 1'b0);
        do_op(1'b0, OP_W,  32'h8000_0010, 32'h0, 32'h7FAD_BEEF, 1'b0);
        do_op(1'b1, OP_H,  32'h8000_0012, 32'hFFFF_8001, 32'h0, 1'b0);
        do_op(1'b0, OP_H,  32'h8000_0012, 32'h0, 32'hFFFF_8001, 1'b0);
        do_op(1'b0, OP_W,  32'h8000_0010, 32'h0, 32'h8001_BEEF, 1'b0);

        // Backpressure: a competing store to the same word must be ignored
        send_req(1'b0, OP_W, 32'h8000_0010, 32'h0, 32'h8001_BEEF, 1'b0);
        get_rsp(5);
        do_op(1'b0, OP_W, 32'h8000_0010, 32'h0, 32'h8001_BEEF, 1'b0);

        // Errors leave memory untouched
        do_op(1'b1, OP_W, 32'h8000_0000, 32'h0123_4567, 32'h0, 1'b0);
        do_op(1'b0, OP_W,   32'h8000_0002, 32'h0, 32'h0, 1'b1);
        do_op(1'b1, OP_H,   32'h8000_0001, 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_op(1'b0, OP_H,   32'h8000_0003, 32'h0, 32'h0, 1'b1);
        do_op(1'b0, OP_W,   32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1);
        do_op(1'b0, OP_W,   32'h8000_4000, 32'h0, 32'h0, 1'b1);
        do_op(1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
        do_op(1'b1, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_op(1'b1, 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_op(1'b1, OP_BU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_op(1'b1, OP_HU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_op(1'b0, OP_W,   32'h8000_0000, 32'h0, 32'h0123_4567, 1'b0);

        // Last in-range word
        do_op(1'b1, OP_W, 32'h8000_3FFC, 32'hCAFE_F00D, 32'h0, 1'b0);
        do_op(1'b0, OP_W, 32'h8000_3FFC, 32'h0, 32'hCAFE_F00D, 1'b0);

        // Reset while BUSY drops the pending store
        do_op(1'b1, OP_W, 32'h8000_0020, 32'h1111_2222, 32'h0, 1'b0);
        send_req(1'b1, OP_W, 32'h8000_0020, 32'hAAAA_5555, 32'h0, 1'b0);
        void'(exp_q.pop_back());
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_req_ready", {31'h0, req_ready}, 32'h1);
        check_eq("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_eq("midrst_mem_data", mem_data, 32'h0);
        check_eq("midrst_rsp_err", {31'h0, rsp_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_op(1'b0, OP_W, 32'h8000_0020, 32'h0, 32'h1111_2222, 1'b0);

        // Latency sweep on the LAT=1 and LAT=5 instances
        @(negedge clk);
        mem_wen = 1'b1; memop = OP_W; mem_addr = 32'h8000_0040; memdata = 32'h5A5A_5A5A;
        sv_req_valid = 1'b1;
        @(posedge clk);
        #1;
        sv_req_valid = 1'b0;
        l1_at = 0;
        l5_at = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (l1_rsp_valid && l1_at == 0) l1_at = c;
            if (l5_rsp_valid && l5_at == 0) l5_at = c;
        end
        check_eq("lat1_rise", l1_at, 1);
        check_eq("lat5_rise", l5_at, 5);
        check_eq("lat1_idle_again", {31'h0, l1_req_ready}, 32'h1);
        check_eq("lat5_idle_again", {31'h0, l5_req_ready}, 32'h1);

        // Random mix of legal accesses against a small word model
        for (int w = 0; w < 8; w++) begin
            model[w] = $urandom;
            do_op(1'b1, OP_W, 32'h8000_0100 + 32'(w * 4), model[w], 32'h0, 1'b0);
        end
        for (int n = 0; n < 40; n++) begin
            int          w;
            logic        wen;
            logic [2:0]  op;
            logic [1:0]  a;
            logic [31:0] d;
            w   = $urandom_range(0, 7);
            wen = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       op = OP_B;
                1:       op = OP_H;
                2:       op = OP_W;
                3:       op = wen ? OP_B : OP_BU;
                default: op = wen ? OP_H : OP_HU;
            endcase
            a = 2'($urandom_range(0, 3));
            if (op == OP_H || op == OP_HU) a[0] = 1'b0;
            if (op == OP_W) a = 2'b00;
            d = $urandom;
            if (wen) begin
                model[w] = model_store(op, a, model[w], d);
                do_op(1'b1, op, 32'h8000_0100 + 32'(w * 4) + 32'(a), d, 32'h0, 1'b0);
            end else begin
                do_op(1'b0, op, 32'h8000_0100 + 32'(w * 4) + 32'(a), d,
                      model_load(op, a, model[w]), 1'b0);
            end
        end

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
